// File: rtl/vlq_stream_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vlq_decoder_pkg
//  Description : Shared definitions for the VLQ stream decoder: byte-format
//                constants and the decode state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package vlq_decoder_pkg;

    // LEB128-style byte: bit 7 = "more bytes follow", bits 6:0 = payload
    localparam int VLQ_CONT_BIT  = 7;
    localparam int VLQ_PAYLOAD_W = 7;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_DATA = 3'd2,
        ST_PUSH = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/vlq_stream_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : vlq_stream_decoder_if
//  Description : Program-memory read port and instruction-FIFO write port of
//                the VLQ stream decoder.
//                  mem_rd/mem_addr  : read strobe and byte address
//                  mem_data         : read data, valid one cycle after mem_rd
//                  fifo_full        : FIFO cannot accept a write this cycle
//                  fifo_wr/fifo_data: one-cycle write of a decoded value
//                master = decoder side, slave = memory/FIFO side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface vlq_stream_decoder_if #(
    parameter int ADDR_WIDTH  = 16,
    parameter int INSTR_WIDTH = 32
);
    logic                   mem_rd;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic [7:0]             mem_data;
    logic                   fifo_full;
    logic                   fifo_wr;
    logic [INSTR_WIDTH-1:0] fifo_data;

    modport master (
        output mem_rd, mem_addr, fifo_wr, fifo_data,
        input  mem_data, fifo_full
    );

    modport slave (
        input  mem_rd, mem_addr, fifo_wr, fifo_data,
        output mem_data, fifo_full
    );
endinterface
`default_nettype wire

// File: rtl/vlq_stream_decoder_accum.sv
`default_nettype none
// ============================================================================
//  Module      : vlq_accum
//  Description : Value accumulator for the VLQ decoder. ORs a 7-bit payload
//                into the accumulator at bit 7*group and tracks the group
//                index. Flags payload bits that would land at or above
//                INSTR_WIDTH, and whether the current group is the last one
//                allowed.
//  Ports       : clk, reset (async, active-low), clear, add, payload,
//                acc, overflow, last_group
//  Revision    : 1.0 - initial release
// ============================================================================
module vlq_accum
    import vlq_decoder_pkg::*;
#(
    parameter int INSTR_WIDTH = 32,
    parameter int MAX_GROUPS  = 5
) (
    input  wire logic                     clk,
    input  wire logic                     reset,
    input  wire logic                     clear,
    input  wire logic                     add,
    input  wire logic [VLQ_PAYLOAD_W-1:0] payload,
    output logic      [INSTR_WIDTH-1:0]   acc,
    output logic                          overflow,
    output logic                          last_group
);
    // Wide enough that the highest possible group still fits, so the
    // out-of-range slice always exists even when 7*MAX_GROUPS == INSTR_WIDTH.
    localparam int c_WIDE_W  = INSTR_WIDTH + VLQ_PAYLOAD_W * MAX_GROUPS;
    localparam int c_GROUP_W = $clog2(MAX_GROUPS + 1);

    logic [INSTR_WIDTH-1:0] r_acc;
    logic [c_GROUP_W-1:0]   r_group;
    logic [c_WIDE_W-1:0]    w_shifted;

    always_comb begin
        w_shifted  = c_WIDE_W'(payload) << (VLQ_PAYLOAD_W * int'(r_group));
        overflow   = |w_shifted[c_WIDE_W-1:INSTR_WIDTH];
        last_group = (r_group == c_GROUP_W'(MAX_GROUPS - 1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc   <= '0;
            r_group <= '0;
        end else if (clear) begin
            r_acc   <= '0;
            r_group <= '0;
        end else if (add) begin
            r_acc   <= r_acc | w_shifted[INSTR_WIDTH-1:0];
            r_group <= r_group + c_GROUP_W'(1);
        end
    end

    assign acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/vlq_stream_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : vlq_stream_decoder
//  Description : Walks byte-wide program memory from start_addr, decodes
//                LEB128-style unsigned values and pushes each into the
//                instruction FIFO until TERM_ZEROS consecutive zero values
//                have been pushed. Overflowing values stop the stream with err.
//  Ports       : clk, reset (async, active-low)
//                start/start_addr  : begin decoding (IDLE/DONE/ERR only)
//                abort             : synchronous return to IDLE
//                bus               : memory read + FIFO write port
//                busy/done/err     : status (done/err sticky until start)
//                addr_out          : address after the last consumed byte
//                instr_count       : values pushed, saturating
//  Revision    : 1.0 - initial release
// ============================================================================
module vlq_stream_decoder
    import vlq_decoder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int INSTR_WIDTH = 32,
    parameter int MAX_GROUPS  = 5,
    parameter int TERM_ZEROS  = 2,
    parameter int COUNT_WIDTH = 16
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    input  wire logic                   start,
    input  wire logic [ADDR_WIDTH-1:0]  start_addr,
    input  wire logic                   abort,
    vlq_stream_decoder_if.master        bus,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic [ADDR_WIDTH-1:0]       addr_out,
    output logic [COUNT_WIDTH-1:0]      instr_count
);
    localparam int c_RUN_W = $clog2(TERM_ZEROS + 1);

    state_t                   r_state;
    state_t                   w_next;
    logic [ADDR_WIDTH-1:0]    r_ptr;
    logic [COUNT_WIDTH-1:0]   r_count;
    logic [c_RUN_W-1:0]       r_zero_run;

    logic                     w_cont;
    logic [VLQ_PAYLOAD_W-1:0] w_payload;
    logic [INSTR_WIDTH-1:0]   w_acc;
    logic                     w_overflow;
    logic                     w_last_group;
    logic                     w_bad;
    logic [c_RUN_W-1:0]       w_run_next;
    logic                     w_mem_rd;
    logic                     w_fifo_wr;
    logic                     w_acc_clear;
    logic                     w_acc_add;
    logic                     w_ptr_inc;
    logic                     w_start_go;

    assign w_cont    = bus.mem_data[VLQ_CONT_BIT];
    assign w_payload = bus.mem_data[VLQ_PAYLOAD_W-1:0];

    // A continuation flag on the last permitted group is as fatal as
    // payload bits beyond the value width.
    assign w_bad      = w_overflow | (w_cont & w_last_group);
    assign w_run_next = (w_acc == '0) ? r_zero_run + c_RUN_W'(1) : '0;

    vlq_accum #(
        .INSTR_WIDTH (INSTR_WIDTH),
        .MAX_GROUPS  (MAX_GROUPS)
    ) u_accum (
        .clk        (clk),
        .reset      (reset),
        .clear      (w_acc_clear),
        .add        (w_acc_add),
        .payload    (w_payload),
        .acc        (w_acc),
        .overflow   (w_overflow),
        .last_group (w_last_group)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_mem_rd    = 1'b0;
        w_fifo_wr   = 1'b0;
        w_acc_clear = 1'b0;
        w_acc_add   = 1'b0;
        w_ptr_inc   = 1'b0;
        w_start_go  = 1'b0;

        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    w_start_go  = 1'b1;
                    w_acc_clear = 1'b1;
                    w_next      = ST_RD;
                end
            end
            ST_RD: begin
                w_mem_rd = 1'b1;
                w_next   = ST_DATA;
            end
            ST_DATA: begin
                // The faulty byte is still consumed so addr_out points past it.
                w_ptr_inc = 1'b1;
                if (w_bad) begin
                    w_next = ST_ERR;
                end else begin
                    w_acc_add = 1'b1;
                    w_next    = w_cont ? ST_RD : ST_PUSH;
                end
            end
            ST_PUSH: begin
                if (!bus.fifo_full) begin
                    w_fifo_wr   = 1'b1;
                    w_acc_clear = 1'b1;
                    w_next      = (w_run_next == c_RUN_W'(TERM_ZEROS)) ? ST_DONE : ST_RD;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase

        // Abort overrides everything, including a simultaneous start; the
        // partial value is dropped but pointer and counters are kept.
        if (abort) begin
            w_next      = ST_IDLE;
            w_mem_rd    = 1'b0;
            w_fifo_wr   = 1'b0;
            w_acc_add   = 1'b0;
            w_ptr_inc   = 1'b0;
            w_start_go  = 1'b0;
            w_acc_clear = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr      <= '0;
            r_count    <= '0;
            r_zero_run <= '0;
        end else begin
            if (w_start_go) begin
                r_ptr      <= start_addr;
                r_count    <= '0;
                r_zero_run <= '0;
            end
            if (w_ptr_inc) begin
                r_ptr <= r_ptr + ADDR_WIDTH'(1);
            end
            if (w_fifo_wr) begin
                if (r_count != '1) begin
                    r_count <= r_count + COUNT_WIDTH'(1);
                end
                r_zero_run <= w_run_next;
            end
        end
    end

    assign bus.mem_rd    = w_mem_rd;
    assign bus.mem_addr  = r_ptr;
    assign bus.fifo_wr   = w_fifo_wr;
    assign bus.fifo_data = w_acc;

    assign busy        = (r_state == ST_RD) || (r_state == ST_DATA) || (r_state == ST_PUSH);
    assign done        = (r_state == ST_DONE);
    assign err         = (r_state == ST_ERR);
    assign addr_out    = r_ptr;
    assign instr_count = r_count;

endmodule
`default_nettype wire

// File: doc/vlq_stream_decoder.md
# vlq_stream_decoder

Parametrised successor to the calculator's instruction decoder. Walks a byte-wide program memory from a start address and decodes LEB128-style variable-length unsigned integers: bit 7 is the continuation flag, bits 6:0 are the payload, least-significant group first. Each decoded value is pushed into the instruction FIFO until a configurable run of consecutive zero values terminates the stream. Adds what the previous decoder lacked: an integrated decode FSM, overflow detection, abort, and an instruction count.

## Interface
- ADDR_WIDTH, 16, program memory address width
- INSTR_WIDTH, 32, decoded value width and FIFO data width
- MAX_GROUPS, 5, maximum encoded bytes per value; must be ≥ ceil(INSTR_WIDTH/7)
- TERM_ZEROS, 2, number of consecutive zero values that ends the stream (≥1)
- COUNT_WIDTH, 16, instruction counter width
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that begins decoding at start_addr
- start_addr  in  ADDR_WIDTH  first byte address
- abort  in  1  synchronous abort, returns to IDLE
- mem_rd  out  1  read strobe
- mem_addr  out  ADDR_WIDTH  read address
- mem_data  in  8  read data, valid exactly one cycle after mem_rd
- fifo_full  in  1  FIFO cannot accept a write this cycle
- fifo_wr  out  1  write strobe, one cycle per value
- fifo_data  out  INSTR_WIDTH  decoded value
- busy  out  1  high from the cycle after start until DONE/ERR/IDLE
- done  out  1  sticky; the stream terminated normally
- err  out  1  sticky; a value overflowed
- addr_out  out  ADDR_WIDTH  address following the last byte consumed
- instr_count  out  COUNT_WIDTH  values pushed, saturating

## Operation
- States: IDLE, RD, DATA, PUSH, DONE, ERR.
- IDLE: on start, ptr←start_addr, accumulator, group index, zero-run and instr_count cleared, done/err cleared → RD. start is ignored in every other state.
- RD: mem_rd=1, mem_addr=ptr → DATA.
- DATA: acc |= payload << (7·group); ptr++; group++.
  - Overflow (→ERR): payload bits landing at or above INSTR_WIDTH are nonzero, or bit 7 is set with group+1 = MAX_GROUPS.
  - Otherwise bit 7 set → RD; bit 7 clear → PUSH.
- PUSH: while fifo_full, stall with fifo_wr=0. Once fifo_full=0: fifo_wr=1 and fifo_data=acc for one cycle; instr_count++ (saturating at all-ones); zero_run = (acc==0) ? zero_run+1 : 0; acc and group cleared. If the new zero_run equals TERM_ZEROS → DONE, otherwise → RD.
- Terminating zeros are pushed to the FIFO.
- DONE: done=1, busy=0. ERR: err=1, busy=0, no push of the faulty value. Both hold until the next start, which is accepted from DONE/ERR as from IDLE.
- addr_out always reflects ptr (the address after the last consumed byte), including on ERR.
- abort in any state → IDLE the next cycle. No write that cycle; done and err stay 0; counters keep their values.
- Reset clears every output and register to 0 (mem_addr, fifo_data, addr_out, instr_count included); state = IDLE. Reset mid-stream discards the partial value.

## Timing
- Single-byte value with the FIFO not full: RD → DATA → PUSH, i.e. 3 cycles from read strobe to fifo_wr. Each extra byte adds 2 cycles.
- start in cycle t → mem_rd in cycle t+1.
- fifo_wr is asserted only in a cycle where fifo_full=0. If fifo_full is sampled high, the write waits for the next cycle.
- done/err rise the cycle after the final PUSH/DATA.
- abort takes priority over every transition. start and abort in the same cycle: abort wins.
- ptr wraps modulo 2^ADDR_WIDTH without error.

## Structure
- Package vlq_decoder_pkg: state enum, VLQ_CONT_BIT=7, VLQ_PAYLOAD_W=7.
- Sub-module vlq_accum: group shift/OR, overflow check, clear. Combinational plus an accumulator register, parametrised by INSTR_WIDTH/MAX_GROUPS.

## Test plan
- mem[0x10..]=05,00,00, start_addr=0x10 → FIFO gets 5,0,0; done=1, addr_out=0x13, instr_count=3, err=0.
- mem=E5,8E,26,00,00 → first push 624485 (0x98765) 7 cycles after start; total 3 pushes; addr_out=start+5.
- mem=FF,FF,FF,FF,0F → 0xFFFFFFFF pushed. mem=FF,FF,FF,FF,1F → err=1, no push, addr_out=start+5.
- mem=00,03,00,00 with TERM_ZEROS=2 → 4 pushes (0,3,0,0); the zero run resets on 3.
- fifo_full held for 4 cycles at the first PUSH → fifo_wr is delayed exactly 4 cycles, data intact, no duplicate write.
- reset low mid-multi-byte value, or abort in DATA → all outputs 0 / IDLE, no write. A following start decodes cleanly.
